// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: read/write control registers, live read-only status
// words, a sticky write-one-to-clear event register with an interrupt mask.
//
// Handshake rule on every channel: a beat transfers on a rising clock edge where
// both valid and ready are 1; valid never waits on ready, and the sender holds
// its payload stable until that edge.
module axi_lite_regbank #(
    parameter int                   N_CTRL     = 22,
    parameter int                   N_STATUS   = 7,
    parameter int                   N_EVENT    = 8,
    parameter int                   ADDR_WIDTH = 12,
    parameter logic [32*N_CTRL-1:0] CTRL_RESET = '0
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [32*N_CTRL-1:0]     ctrl_regs,
    output logic [N_CTRL-1:0]        ctrl_wr_pulse,
    input  logic [32*N_STATUS-1:0]   status_regs,
    output logic [N_STATUS-1:0]      status_rd_pulse,
    input  logic [N_EVENT-1:0]       event_in,
    output logic                     irq
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int E_IDX = N_CTRL + N_STATUS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-side holding registers and response
    logic              aw_full_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic              w_full_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    // Register file
    logic [31:0]        ctrl_q [N_CTRL];
    logic [N_CTRL-1:0]  ctrl_wr_pulse_q;
    logic [N_EVENT-1:0] event_q, event_d;
    logic [N_EVENT-1:0] mask_q, mask_d;

    // Read side
    logic                rvalid_q;
    logic [31:0]         rdata_q, rd_data_d;
    logic [1:0]          rresp_q, rd_resp_d;
    logic [N_STATUS-1:0] status_rd_pulse_q, rd_pulse_d;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] wr_idx, ar_idx;
    logic [31:0] byte_mask, wr_bits;
    logic        wr_is_ctrl, wr_is_event, wr_is_mask, wr_ok;
    logic [N_EVENT-1:0] ev_clr;

    // Address bits below word granularity carry no meaning here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Ready is withheld during reset and while a response is outstanding.
    assign s_axi_awready = !aw_full_q && !bvalid_q && !s_axi_areset;
    assign s_axi_wready  = !w_full_q  && !bvalid_q && !s_axi_areset;
    assign s_axi_arready = !rvalid_q && !s_axi_areset;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid  && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_full_q && w_full_q;

    assign wr_idx = 32'(aw_idx_q);
    assign ar_idx = 32'(s_axi_araddr[ADDR_WIDTH-1:2]);

    // Decode of the committed write: byte enables and target class
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            byte_mask[8*b +: 8] = {8{w_strb_q[b]}};
        end
        wr_bits     = w_data_q & byte_mask;
        wr_is_ctrl  = wr_idx < 32'(N_CTRL);
        wr_is_event = wr_idx == 32'(E_IDX);
        wr_is_mask  = wr_idx == 32'(E_IDX + 1);
        wr_ok       = wr_is_ctrl || wr_is_event || wr_is_mask;
    end

    // Sticky events: a new set pulse beats a simultaneous write-one-to-clear
    always_comb begin
        ev_clr  = (commit && wr_is_event) ? wr_bits[N_EVENT-1:0] : '0;
        event_d = (event_q & ~ev_clr) | event_in;
        mask_d  = mask_q;
        if (commit && wr_is_mask) begin
            mask_d = (mask_q & ~byte_mask[N_EVENT-1:0]) | wr_bits[N_EVENT-1:0];
        end
    end

    // AW/W holding registers fill independently and drain together on commit
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end else if (commit) begin
                aw_full_q <= 1'b0;
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end else if (commit) begin
                w_full_q <= 1'b0;
            end
        end
    end

    // Write response: raised after commit, held until the master takes it
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Control registers with byte strobes and a one-cycle write pulse
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            for (int k = 0; k < N_CTRL; k++) begin
                ctrl_q[k] <= CTRL_RESET[32*k +: 32];
            end
            ctrl_wr_pulse_q <= '0;
        end else begin
            ctrl_wr_pulse_q <= '0;
            for (int k = 0; k < N_CTRL; k++) begin
                if (commit && wr_idx == 32'(k)) begin
                    ctrl_q[k] <= (ctrl_q[k] & ~byte_mask) | wr_bits;
                    if (w_strb_q != 4'b0000) begin
                        ctrl_wr_pulse_q[k] <= 1'b1;
                    end
                end
            end
        end
    end

    // Event and mask registers
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            event_q <= '0;
            mask_q  <= '0;
        end else begin
            event_q <= event_d;
            mask_q  <= mask_d;
        end
    end

    // Read mux from the live AR address; unmapped words answer DEADBEEF/SLVERR
    always_comb begin
        rd_data_d  = 32'hDEADBEEF;
        rd_resp_d  = RESP_SLVERR;
        rd_pulse_d = '0;
        for (int k = 0; k < N_CTRL; k++) begin
            if (ar_idx == 32'(k)) begin
                rd_data_d = ctrl_q[k];
                rd_resp_d = RESP_OKAY;
            end
        end
        for (int k = 0; k < N_STATUS; k++) begin
            if (ar_idx == 32'(N_CTRL + k)) begin
                rd_data_d     = status_regs[32*k +: 32];
                rd_resp_d     = RESP_OKAY;
                rd_pulse_d[k] = 1'b1;
            end
        end
        if (ar_idx == 32'(E_IDX)) begin
            rd_data_d              = '0;
            rd_data_d[N_EVENT-1:0] = event_q;
            rd_resp_d              = RESP_OKAY;
        end
        if (ar_idx == 32'(E_IDX + 1)) begin
            rd_data_d              = '0;
            rd_data_d[N_EVENT-1:0] = mask_q;
            rd_resp_d              = RESP_OKAY;
        end
    end

    // Read channel: capture on AR handshake, hold until rready
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rvalid_q          <= 1'b0;
            rdata_q           <= '0;
            rresp_q           <= RESP_OKAY;
            status_rd_pulse_q <= '0;
        end else begin
            status_rd_pulse_q <= '0;
            if (ar_hs) begin
                rvalid_q          <= 1'b1;
                rdata_q           <= rd_data_d;
                rresp_q           <= rd_resp_d;
                status_rd_pulse_q <= rd_pulse_d;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_CTRL; g++) begin : g_ctrl_flat
        assign ctrl_regs[32*g +: 32] = ctrl_q[g];
    end

    assign s_axi_bvalid    = bvalid_q;
    assign s_axi_bresp     = bresp_q;
    assign s_axi_rvalid    = rvalid_q;
    assign s_axi_rdata     = rdata_q;
    assign s_axi_rresp     = rresp_q;
    assign ctrl_wr_pulse   = ctrl_wr_pulse_q;
    assign status_rd_pulse = status_rd_pulse_q;
    assign irq             = |(event_q & mask_q);

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank: directed scenarios followed by
// randomized traffic, compared against an array-based register map model.
module tb_axi_lite_regbank;

  localparam int N_CTRL     = 22;
  localparam int N_STATUS   = 7;
  localparam int N_EVENT    = 8;
  localparam int ADDR_WIDTH = 12;
  localparam int E_IDX      = N_CTRL + N_STATUS;
  localparam int CW         = 32 * N_CTRL;
  localparam logic [CW-1:0] TB_CTRL_RESET =
    {32'h5A5A0000, {19{32'h00000000}}, 32'hCAFE0001, 32'h00000000};

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_WIDTH-1:0] s_axi_awaddr = '0;
  logic                  s_axi_awvalid = 1'b0;
  logic                  s_axi_awready;
  logic [31:0]           s_axi_wdata = '0;
  logic [3:0]            s_axi_wstrb = '0;
  logic                  s_axi_wvalid = 1'b0;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready = 1'b0;
  logic [ADDR_WIDTH-1:0] s_axi_araddr = '0;
  logic                  s_axi_arvalid = 1'b0;
  logic                  s_axi_arready;
  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready = 1'b0;
  logic [CW-1:0]         ctrl_regs;
  logic [N_CTRL-1:0]     ctrl_wr_pulse;
  logic [32*N_STATUS-1:0] status_regs = '0;
  logic [N_STATUS-1:0]   status_rd_pulse;
  logic [N_EVENT-1:0]    event_in = '0;
  logic                  irq;

  axi_lite_regbank #(
    .N_CTRL(N_CTRL), .N_STATUS(N_STATUS), .N_EVENT(N_EVENT),
    .ADDR_WIDTH(ADDR_WIDTH), .CTRL_RESET(TB_CTRL_RESET)
  ) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse),
    .status_regs(status_regs), .status_rd_pulse(status_rd_pulse),
    .event_in(event_in), .irq(irq)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int pulse_total = 0;
  int pulse2 = 0;
  int exp_pulse_total = 0;

  logic [31:0]        ctrl_m [N_CTRL];
  logic [N_EVENT-1:0] event_m;
  logic [N_EVENT-1:0] mask_m;

  // Count write pulses, sampled mid-cycle
  always @(negedge clk) begin
    pulse_total += $countones(ctrl_wr_pulse);
    pulse2      += int'(ctrl_wr_pulse[2]);
  end

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_CTRL; k++) ctrl_m[k] = TB_CTRL_RESET[32*k +: 32];
    event_m = '0;
    mask_m  = '0;
  endtask

  function automatic logic [CW-1:0] model_flat();
    logic [CW-1:0] v;
    for (int k = 0; k < N_CTRL; k++) v[32*k +: 32] = ctrl_m[k];
    return v;
  endfunction

  // Register map semantics: byte-strobed ctrl/mask, W1C event, errors elsewhere
  task automatic model_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [N_EVENT-1:0] ev,
                             output logic [1:0] resp);
    int idx;
    logic [31:0] bm;
    idx = int'(addr) / 4;
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{strb[b]}};
    resp = 2'b10;
    if (idx < N_CTRL) begin
      ctrl_m[idx] = (ctrl_m[idx] & ~bm) | (data & bm);
      if (strb != 4'h0) exp_pulse_total++;
      resp = 2'b00;
    end else if (idx == E_IDX) begin
      for (int i = 0; i < N_EVENT; i++) if (data[i] && bm[i]) event_m[i] = 1'b0;
      resp = 2'b00;
    end else if (idx == E_IDX + 1) begin
      for (int i = 0; i < N_EVENT; i++) if (bm[i]) mask_m[i] = data[i];
      resp = 2'b00;
    end
    event_m = event_m | ev;
  endtask

  task automatic model_read(input logic [11:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic [N_STATUS-1:0] pulse);
    int idx;
    idx   = int'(addr) / 4;
    data  = 32'hDEADBEEF;
    resp  = 2'b10;
    pulse = '0;
    if (idx < N_CTRL) begin
      data = ctrl_m[idx]; resp = 2'b00;
    end else if (idx < E_IDX) begin
      data = status_regs[32*(idx-N_CTRL) +: 32]; resp = 2'b00;
      pulse[idx-N_CTRL] = 1'b1;
    end else if (idx == E_IDX) begin
      data = 32'(event_m); resp = 2'b00;
    end else if (idx == E_IDX + 1) begin
      data = 32'(mask_m); resp = 2'b00;
    end
  endtask

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [N_EVENT-1:0] ev);
    logic [1:0] exp_resp;
    logic [1:0] resp0;
    bit b_ok;
    model_write(addr, data, strb, ev, exp_resp);
    fork
      begin
        bit ok;
        repeat (aw_dly) begin @(posedge clk); #1; end
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin @(negedge clk); ok = s_axi_awready; end
        check("aw_handshake", ok, 1'b1);
        @(posedge clk); #1; s_axi_awvalid = 1'b0;
      end
      begin
        bit ok;
        repeat (w_dly) begin @(posedge clk); #1; end
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin @(negedge clk); ok = s_axi_wready; end
        check("w_handshake", ok, 1'b1);
        @(posedge clk); #1; s_axi_wvalid = 1'b0;
      end
    join
    if (ev != '0) begin
      event_in = ev;
      @(posedge clk); #1;
      event_in = '0;
    end
    b_ok = 1'b0;
    for (int n = 0; n < 40 && !b_ok; n++) begin @(negedge clk); b_ok = s_axi_bvalid; end
    check("bvalid_seen", b_ok, 1'b1);
    resp0 = s_axi_bresp;
    check("bresp", resp0, exp_resp);
    check("awready_during_b", s_axi_awready, 1'b0);
    check("wready_during_b", s_axi_wready, 1'b0);
    repeat (b_dly) begin
      @(negedge clk);
      check("bvalid_hold", s_axi_bvalid, 1'b1);
      check("bresp_hold", s_axi_bresp, resp0);
      check("awready_hold", s_axi_awready, 1'b0);
      check("wready_hold", s_axi_wready, 1'b0);
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("bvalid_clear", s_axi_bvalid, 1'b0);
    check("ctrl_regs", ctrl_regs, model_flat());
    check("irq_after_write", irq, |(event_m & mask_m));
    check("wr_pulse_count", pulse_total, exp_pulse_total);
  endtask

  task automatic axi_read(input logic [11:0] addr);
    logic [31:0] ed;
    logic [1:0] er;
    logic [N_STATUS-1:0] ep;
    bit ok;
    model_read(addr, ed, er, ep);
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin @(negedge clk); ok = s_axi_arready; end
    check("ar_handshake", ok, 1'b1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    check("rvalid", s_axi_rvalid, 1'b1);
    check("rdata", s_axi_rdata, ed);
    check("rresp", s_axi_rresp, er);
    check("status_rd_pulse", status_rd_pulse, ep);
    check("arready_busy", s_axi_arready, 1'b0);
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    check("rvalid_clear", s_axi_rvalid, 1'b0);
    check("status_rd_pulse_end", status_rd_pulse, '0);
  endtask

  task automatic pulse_event(input logic [N_EVENT-1:0] ev);
    event_in = ev;
    @(posedge clk); #1;
    event_in = '0;
    event_m = event_m | ev;
    check("irq_after_event", irq, |(event_m & mask_m));
  endtask

  task automatic randomize_status();
    for (int k = 0; k < N_STATUS; k++) status_regs[32*k +: 32] = $urandom;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    randomize_status();

    // Asynchronous reset values, before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_awready", s_axi_awready, 1'b0);
    check("rst_wready", s_axi_wready, 1'b0);
    check("rst_arready", s_axi_arready, 1'b0);
    check("rst_bvalid", s_axi_bvalid, 1'b0);
    check("rst_rvalid", s_axi_rvalid, 1'b0);
    check("rst_bresp", s_axi_bresp, 2'b00);
    check("rst_rresp", s_axi_rresp, 2'b00);
    check("rst_rdata", s_axi_rdata, 32'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_ctrl", ctrl_regs, TB_CTRL_RESET);
    check("rst_wr_pulse", ctrl_wr_pulse, '0);
    check("rst_rd_pulse", status_rd_pulse, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_awready", s_axi_awready, 1'b1);
    check("post_rst_wready", s_axi_wready, 1'b1);
    check("post_rst_arready", s_axi_arready, 1'b1);

    // W two cycles ahead of AW to ctrl reg 2
    axi_write(12'h008, 32'hA5A5A5A5, 4'hF, 2, 0, 0, '0);
    check("reg2_value", ctrl_regs[95:64], 32'hA5A5A5A5);
    check("reg2_pulse_once", pulse2, 1);

    // Single byte strobe into reg 0
    axi_write(12'h000, 32'h11223344, 4'hF, 0, 0, 0, '0);
    axi_write(12'h000, 32'h0000BB00, 4'h2, 0, 1, 0, '0);
    check("reg0_strobe", ctrl_regs[31:0], 32'h1122BB44);

    // Status read, invalid read, readback of reset-valued ctrl
    axi_read(12'h05C);
    axi_read(12'h0F0);
    axi_read(12'h004);
    axi_read(12'h054);

    // Events, mask, irq, W1C and set-wins coincidence
    axi_write(12'h078, 32'h00000008, 4'hF, 0, 0, 0, '0);
    pulse_event(8'h08);
    check("irq_set", irq, 1'b1);
    axi_write(12'h074, 32'h00000008, 4'hF, 0, 0, 0, '0);
    check("irq_w1c", irq, 1'b0);
    pulse_event(8'h08);
    axi_write(12'h074, 32'h00000008, 4'hF, 0, 0, 0, 8'h08);
    check("irq_set_wins", irq, 1'b1);
    axi_read(12'h074);
    axi_read(12'h078);

    // Slow bready, error writes, zero-strobe ctrl write
    axi_write(12'h014, 32'hDEAD0014, 4'hF, 0, 0, 5, '0);
    axi_write(12'h058, 32'hFFFFFFFF, 4'hF, 1, 0, 0, '0);
    axi_write(12'h3FC, 32'h12345678, 4'hF, 0, 0, 1, '0);
    axi_write(12'h018, 32'hFFFFFFFF, 4'h0, 0, 0, 0, '0);

    // Read and write channels in flight together
    fork
      axi_write(12'h00C, 32'h0BADF00D, 4'hF, 0, 1, 2, '0);
      axi_read(12'h060);
    join
    axi_read(12'h00C);

    // Reset between AW and W acceptance
    s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_ctrl", ctrl_regs, TB_CTRL_RESET);
    check("midrst_irq", irq, 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_awready", s_axi_awready, 1'b1);
    check("midrst_wready", s_axi_wready, 1'b1);
    check("midrst_bvalid", s_axi_bvalid, 1'b0);
    axi_write(12'h010, 32'h55AA55AA, 4'hF, 0, 2, 0, '0);
    axi_read(12'h010);
    axi_read(12'h074);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      int idx;
      int kind;
      logic [11:0] addr;
      randomize_status();
      idx = $urandom_range(0, E_IDX + 4);
      if ($urandom_range(0, 7) == 0) idx = $urandom_range(E_IDX + 2, 1023);
      addr = 12'(idx * 4 + int'($urandom_range(0, 3)));
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        axi_write(addr, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), '0);
      end else if (kind < 9) begin
        axi_read(addr);
      end else begin
        pulse_event(N_EVENT'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_lite_regbank.md
AXI_LITE_REGBANK -- requirements
Module: axi_lite_regbank

Interface
REQ-001 SHALL take parameter N_CTRL, default 22: number of read/write control registers.
REQ-002 SHALL take parameter N_STATUS, default 7: number of read-only status registers.
REQ-003 SHALL take parameter N_EVENT, default 8, range 1..32: number of sticky event bits.
REQ-004 SHALL take parameter ADDR_WIDTH, default 12: AXI address width; word index = addr[ADDR_WIDTH-1:2].
REQ-005 SHALL take parameter CTRL_RESET, default all-zero, 32*N_CTRL bits: per-register reset values.
REQ-006 SHALL have port s_axi_aclk, input, 1: the only clock.
REQ-007 SHALL have port s_axi_areset, input, 1: reset, asynchronous, active-high.
REQ-008 SHALL have ports s_axi_awaddr (input, ADDR_WIDTH), s_axi_awvalid (input, 1), s_axi_awready (output, 1): write address channel.
REQ-009 SHALL have ports s_axi_wdata (input, 32), s_axi_wstrb (input, 4), s_axi_wvalid (input, 1), s_axi_wready (output, 1): write data channel.
REQ-010 SHALL have ports s_axi_bresp (output, 2), s_axi_bvalid (output, 1), s_axi_bready (input, 1): write response channel.
REQ-011 SHALL have ports s_axi_araddr (input, ADDR_WIDTH), s_axi_arvalid (input, 1), s_axi_arready (output, 1): read address channel.
REQ-012 SHALL have ports s_axi_rdata (output, 32), s_axi_rresp (output, 2), s_axi_rvalid (output, 1), s_axi_rready (input, 1): read data channel.
REQ-013 SHALL have port ctrl_regs, output, 32*N_CTRL: flattened control registers, register k at bits [32k+31:32k].
REQ-014 SHALL have port ctrl_wr_pulse, output, N_CTRL: one-cycle pulse, bit k set when register k is written.
REQ-015 SHALL have port status_regs, input, 32*N_STATUS: flattened status values, same clock domain.
REQ-016 SHALL have port status_rd_pulse, output, N_STATUS: one-cycle pulse on acceptance of a read of status k.
REQ-017 SHALL have port event_in, input, N_EVENT: event set pulses.
REQ-018 SHALL have port irq, output, 1: interrupt, equal to OR over (event_reg AND event_mask).

Function
REQ-019 SHALL decode the word map as: ctrl at idx 0..N_CTRL-1; status at idx N_CTRL..N_CTRL+N_STATUS-1; EVENT at idx E=N_CTRL+N_STATUS; EVENT_MASK at idx E+1; all other indices invalid.
REQ-020 SHALL accept AW and W independently and in either order, each into its own one-entry holding register.
REQ-021 SHALL assert awready (wready) exactly when its holding register is empty and bvalid=0.
REQ-022 SHALL commit a write in the first cycle both holding registers are full, then set bvalid the next cycle and empty both holding registers.
REQ-023 SHALL hold bvalid and bresp stable until bready=1, and clear bvalid in the cycle following bready=1.
REQ-024 SHALL apply wstrb per byte on ctrl and EVENT_MASK writes.
REQ-025 SHALL clear EVENT bits written as 1 in strobed bytes (W1C) and leave bits written as 0 unchanged.
REQ-026 SHALL return bresp OKAY (00) for ctrl, EVENT and EVENT_MASK writes, and SLVERR (10) with no state change for status or invalid writes.
REQ-027 SHALL pulse ctrl_wr_pulse[k] in the cycle after a ctrl commit to register k with wstrb not equal to 0.
REQ-028 SHALL assert arready exactly when rvalid=0.
REQ-029 SHALL register rdata/rresp on AR handshake, set rvalid the next cycle, and hold both stable until rready=1.
REQ-030 SHALL read back: ctrl value; live status_regs value with OKAY; EVENT/EVENT_MASK zero-extended above N_EVENT; invalid index returns 32'hDEADBEEF with SLVERR.
REQ-031 SHALL pulse status_rd_pulse[k] for exactly one cycle, in the cycle after the AR handshake.
REQ-032 SHALL set event_reg[i] on every cycle event_in[i]=1; when a set coincides with a W1C of the same bit, set SHALL win.
REQ-033 SHALL drive irq combinationally from registered event_reg and event_mask.
REQ-034 SHALL process read and write channels concurrently with no mutual ordering.

Reset
REQ-035 SHALL, while s_axi_areset=1 and asynchronously, force: ctrl=CTRL_RESET; event_reg=0; event_mask=0; holding registers empty; awready, wready, bvalid, arready, rvalid, all pulses and irq at 0; bresp=rresp=00; rdata=0.
REQ-036 SHALL abort any in-flight transaction on reset mid-operation without committing it, and SHALL present ready signals from the first clock after release.

Verification
REQ-037 SHALL pass: W two cycles before AW, addr 0x008, data 0xA5A5A5A5, wstrb 0xF -> ctrl reg 2 = 0xA5A5A5A5, ctrl_wr_pulse[2] pulses once, bresp 00.
REQ-038 SHALL pass: wstrb 0x2, data 0x0000BB00 to reg 0 holding 0x11223344 -> reg 0 = 0x1122BB44.
REQ-039 SHALL pass: with defaults, read idx 23 (addr 0x05C) -> rdata = status_regs[63:32], rresp 00, status_rd_pulse[1] one cycle; read addr 0x0F0 -> 0xDEADBEEF, rresp 10.
REQ-040 SHALL pass: event_in[3] pulse with mask 0x08 -> irq=1; W1C 0x08 to EVENT (addr 0x074) -> irq=0; W1C coinciding with new event_in[3] -> bit stays 1.
REQ-041 SHALL pass: bready held low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout.
REQ-042 SHALL pass: reset asserted between AW and W acceptance -> no register changes; next full write completes normally.
